// File: rtl/adder_result_accum.sv
// Windowed accumulator for the adder stage: sums NUM_SAMPLES sum_i values, counts carries, hands off via valid/ready.
// Optional macros: USE_POWER_PINS (adds VPWR/VGND), ACCUM_SATURATE_EN (clamp instead of wrap on overflow).
module adder_result_accum #(
  parameter int unsigned SUM_W       = 8,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned NUM_SAMPLES = 8,
  localparam int unsigned CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
`ifdef USE_POWER_PINS
  inout  wire               VPWR,
  inout  wire               VGND,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic              carry_i,
  output logic [ACC_W-1:0]  result_o,
  output logic [CNT_W-1:0]  carry_cnt_o,
  output logic              overflow_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam int unsigned EXT_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_ccnt;
  logic [CNT_W-1:0]   w_ccnt_nxt;
  logic [CNT_W-1:0]   r_smp;
  logic [CNT_W-1:0]   w_smp_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [EXT_W-1:0]   w_sum;
  logic               w_last;

  // Carry-out of the widened add is the overflow indication.
  assign w_sum  = {1'b0, r_acc} + EXT_W'(sum_i);
  assign w_last = (r_smp == CNT_W'(NUM_SAMPLES - 1));

  // State register and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ccnt  <= '0;
      r_smp   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ccnt  <= w_ccnt_nxt;
      r_smp   <= w_smp_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ccnt_nxt  = r_ccnt;
    w_smp_nxt   = r_smp;
    w_ovf_nxt   = r_ovf;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_ACCUM;
          w_acc_nxt   = '0;
          w_ccnt_nxt  = '0;
          w_smp_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_ACCUM: begin
`ifdef ACCUM_SATURATE_EN
        w_acc_nxt  = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
        w_acc_nxt  = w_sum[ACC_W-1:0];
`endif
        w_ccnt_nxt = r_ccnt + CNT_W'(carry_i);
        w_smp_nxt  = r_smp + CNT_W'(1);
        if (w_sum[ACC_W]) begin
          w_ovf_nxt = 1'b1;
        end
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_valid_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign result_o    = r_acc;
  assign carry_cnt_o = r_ccnt;
  assign overflow_o  = r_ovf;
  assign valid_o     = r_valid;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_adder_result_accum.sv
// Bench for adder_result_accum: three configurations share one stimulus stream and are checked
// every cycle against a window-level model, plus literal expectations for the key scenarios.
module tb_adder_result_accum;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic        carry;
  logic [7:0]  sum;

  logic [15:0] res0;
  logic [9:0]  res1;
  logic [15:0] res2;
  logic [3:0]  cc0;
  logic [3:0]  cc1;
  logic [0:0]  cc2;
  logic [2:0]  ovf;
  logic [2:0]  val;
  logic [2:0]  busy;

  int total = 0;
  int bad   = 0;

`ifdef USE_POWER_PINS
  wire vpwr = 1'b1;
  wire vgnd = 1'b0;
`endif

  adder_result_accum #(.SUM_W(8), .ACC_W(16), .NUM_SAMPLES(8)) u_dut0 (
`ifdef USE_POWER_PINS
    .VPWR(vpwr), .VGND(vgnd),
`endif
    .clk(clk), .rst_n(rst_n), .start_i(start), .sum_i(sum), .carry_i(carry),
    .result_o(res0), .carry_cnt_o(cc0), .overflow_o(ovf[0]), .valid_o(val[0]),
    .ready_i(ready), .busy_o(busy[0]));

  adder_result_accum #(.SUM_W(8), .ACC_W(10), .NUM_SAMPLES(8)) u_dut1 (
`ifdef USE_POWER_PINS
    .VPWR(vpwr), .VGND(vgnd),
`endif
    .clk(clk), .rst_n(rst_n), .start_i(start), .sum_i(sum), .carry_i(carry),
    .result_o(res1), .carry_cnt_o(cc1), .overflow_o(ovf[1]), .valid_o(val[1]),
    .ready_i(ready), .busy_o(busy[1]));

  adder_result_accum #(.SUM_W(8), .ACC_W(16), .NUM_SAMPLES(1)) u_dut2 (
`ifdef USE_POWER_PINS
    .VPWR(vpwr), .VGND(vgnd),
`endif
    .clk(clk), .rst_n(rst_n), .start_i(start), .sum_i(sum), .carry_i(carry),
    .result_o(res2), .carry_cnt_o(cc2), .overflow_o(ovf[2]), .valid_o(val[2]),
    .ready_i(ready), .busy_o(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window-level model: phase 0 idle, 1 collecting, 2 holding result; tot is the exact window sum.
  int     ns[3] = '{8, 8, 1};
  int     aw[3] = '{16, 10, 16};
  int     ph[3];
  int     mcnt[3];
  longint tot[3];
  longint car[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; mcnt[i] = 0; tot[i] = 0; car[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (ph[i])
          0: if (start) begin ph[i] = 1; mcnt[i] = 0; tot[i] = 0; car[i] = 0; end
          1: begin
            tot[i] += longint'(sum);
            car[i] += longint'(carry);
            mcnt[i]++;
            if (mcnt[i] == ns[i]) ph[i] = 2;
          end
          default: if (ready) ph[i] = 0;
        endcase
      end
    end
  end

  function automatic longint exp_res(int i);
    longint lim = longint'(1) << aw[i];
`ifdef ACCUM_SATURATE_EN
    return (tot[i] >= lim) ? lim - 1 : tot[i];
`else
    return tot[i] % lim;
`endif
  endfunction

  function automatic longint exp_ovf(int i);
    return longint'(tot[i] >= (longint'(1) << aw[i]));
  endfunction

  function automatic longint got_res(int i);
    case (i)
      0: return longint'(res0);
      1: return longint'(res1);
      default: return longint'(res2);
    endcase
  endfunction

  function automatic longint got_cnt(int i);
    case (i)
      0: return longint'(cc0);
      1: return longint'(cc1);
      default: return longint'(cc2);
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    for (int i = 0; i < 3; i++) begin
      chk("valid", i, longint'(val[i]), longint'(ph[i] == 2));
      chk("busy", i, longint'(busy[i]), longint'(ph[i] != 0));
      if (ph[i] != 1) begin
        chk("result", i, got_res(i), exp_res(i));
        chk("carry_cnt", i, got_cnt(i), car[i]);
        chk("overflow", i, longint'(ovf[i]), exp_ovf(i));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic all_zero(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_result"}, i, got_res(i), 0);
      chk({nm, "_cnt"}, i, got_cnt(i), 0);
      chk({nm, "_ovf"}, i, longint'(ovf[i]), 0);
      chk({nm, "_valid"}, i, longint'(val[i]), 0);
      chk({nm, "_busy"}, i, longint'(busy[i]), 0);
    end
  endtask

  task automatic release_all();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic run_window(input logic [7:0] s, input bit rnd);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sum   = rnd ? 8'($urandom) : s;
      carry = rnd ? 1'($urandom) : 1'b0;
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; sum = '0; carry = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    all_zero("reset");
    cmp_model();
    rst_n = 1'b1;

    // T1: 0x10 x8, carries on samples 2,5,7
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      sum   = 8'h10;
      carry = (s == 2 || s == 5 || s == 7);
      tick();
      if (s == 7) chk("t1_valid_early", 0, longint'(val[0]), 0);
    end
    chk("t1_valid", 0, longint'(val[0]), 1);
    chk("t1_result", 0, longint'(res0), 64'h0080);
    chk("t1_cnt", 0, longint'(cc0), 3);
    chk("t1_ovf", 0, longint'(ovf[0]), 0);
    release_all();
    chk("t1_idle_busy", 0, longint'(busy[0]), 0);

    // T2: 0xFF x8 overflows the 10-bit accumulator
    run_window(8'hFF, 1'b0);
`ifdef ACCUM_SATURATE_EN
    chk("t2_result", 1, longint'(res1), 64'h3FF);
`else
    chk("t2_result", 1, longint'(res1), 64'h3F8);
`endif
    chk("t2_ovf", 1, longint'(ovf[1]), 1);
    chk("t2_result_wide", 0, longint'(res0), 64'h07F8);
    chk("t2_ovf_wide", 0, longint'(ovf[0]), 0);
    release_all();

    // T3: result held while consumer stalls; start ignored in DONE
    run_window(8'h00, 1'b1);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      chk("t3_valid_held", 0, longint'(val[0]), 1);
      chk("t3_busy_held", 1, longint'(busy[1]), 1);
    end
    start = 1'b0;
    release_all();
    for (int i = 0; i < 3; i++) begin
      chk("t3_valid_clr", i, longint'(val[i]), 0);
      chk("t3_busy_clr", i, longint'(busy[i]), 0);
    end

    // T4: asynchronous reset mid-window, then a fresh window
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sum = 8'($urandom); carry = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1 all_zero("t4_async");
    model_reset();
    @(negedge clk);
    cmp_model();
    rst_n = 1'b1;
    run_window(8'h03, 1'b0);
    chk("t4_result", 0, longint'(res0), 64'h0018);
    chk("t4_cnt", 0, longint'(cc0), 0);
    release_all();

    // T5: start at handshake edge ignored, start on following edge taken
    run_window(8'h00, 1'b1);
    ready = 1'b1; start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) chk("t5_busy_hs", i, longint'(busy[i]), 0);
    ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) chk("t5_busy_restart", i, longint'(busy[i]), 1);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sum = 8'($urandom); carry = 1'($urandom);
      tick();
    end
    release_all();

    // T6: single-sample window completes two edges after start
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_valid_early", 2, longint'(val[2]), 0);
    sum = 8'h2A; carry = 1'b1;
    tick();
    chk("t6_valid", 2, longint'(val[2]), 1);
    chk("t6_result", 2, longint'(res2), 64'h002A);
    chk("t6_cnt", 2, longint'(cc2), 1);
    for (int k = 0; k < 7; k++) begin
      sum = 8'($urandom); carry = 1'($urandom);
      tick();
    end
    release_all();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      start = ($urandom_range(3) == 0);
      sum   = 8'($urandom);
      carry = 1'($urandom);
      ready = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
